atm_ctrl_param: RTL and testbench
=================================

Name: atm_ctrl_param

Overview:
Parametrised second-generation ATM transaction controller. It replaces the fixed 4-bit-PIN, single-attempt Mealy ATM with a registered-output FSM. New capabilities: an internal vault balance that is decremented on dispense and can be reloaded, a configurable PIN retry count, a timed alarm lockout, and an inactivity timeout. It sits between the card-reader/keypad front end and the dispenser mechanism.

Parameters:
AMT_W, 16, width of amounts and vault balance
PIN_W, 4, PIN width
MAX_TRIES, 3, PIN attempts before lockout (>=1)
TIMEOUT, 32, idle cycles allowed in WAIT_PIN/WAIT_AMT before abort
LOCK_CYC, 8, cycles alarm is held in LOCKOUT
INIT_CASH, 100, vault value after reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
defect  in  1  machine fault
insert_card  in  1  card present level
card_valid  in  1  card data valid
card_undamaged  in  1  card physically ok
pin_strobe  in  1  one-cycle strobe, user_pin valid
user_pin  in  PIN_W  entered PIN
correct_pin  in  PIN_W  PIN stored on card
amt_strobe  in  1  one-cycle strobe, amount_asked valid
amount_asked  in  AMT_W  requested amount
load_strobe  in  1  vault reload strobe
load_amt  in  AMT_W  amount added on reload
green_bulb  out  1  in service, IDLE
red_bulb  out  1  out of service
resubmit  out  1  one-cycle pulse, card rejected
alarm  out  1  high throughout LOCKOUT
not_enough_cash  out  1  one-cycle pulse, request > vault
success  out  1  one-cycle pulse, dispense
dispense_amt  out  AMT_W  amount dispensed, valid with success
vault_cash  out  AMT_W  current vault balance
tries_left  out  $clog2(MAX_TRIES+1)  remaining PIN attempts
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset values: all pulses 0; alarm 0; dispense_amt 0; vault_cash INIT_CASH; tries_left MAX_TRIES; state OOS if INIT_CASH==0, else IDLE. green_bulb and red_bulb are decoded from state.
- All outputs are registered. A decision is visible one cycle after the sampling edge.
- States: OOS=0, IDLE=1, CHECK=2, WAIT_PIN=3, WAIT_AMT=4, DONE=5, LOCKOUT=6.
- OOS: red_bulb=1. Go to IDLE when defect==0 and vault_cash!=0.
- IDLE: green_bulb=1. If insert_card is high, go to CHECK.
- CHECK (1 cycle): if card_valid and card_undamaged, go to WAIT_PIN and set tries_left=MAX_TRIES. Otherwise pulse resubmit and go to DONE.
- WAIT_PIN, on pin_strobe:
  - user_pin==correct_pin: go to WAIT_AMT.
  - mismatch: decrement tries_left. If the result is 0, go to LOCKOUT.
- WAIT_AMT, on amt_strobe:
  - amount_asked==0: cancel, go to DONE.
  - amount_asked>vault_cash: pulse not_enough_cash and stay in WAIT_AMT.
  - otherwise: pulse success, set dispense_amt=amount_asked, vault_cash-=amount_asked, go to DONE.
- Timeout counter: cleared on state entry and on any strobe. On reaching TIMEOUT-1 without a strobe, go to DONE.
- insert_card low in CHECK, WAIT_PIN or WAIT_AMT: abort to IDLE. This has priority over strobes in the same cycle.
- DONE: wait for insert_card==0. Then go to OOS if vault_cash==0, else IDLE.
- LOCKOUT: alarm=1 for exactly LOCK_CYC cycles, then go to DONE. Strobes are ignored.
- defect==1 forces OOS next cycle from any state, except that LOCKOUT completes its LOCK_CYC first. A pending strobe in the same cycle is dropped, with no dispense.
- load_strobe is accepted only in OOS or IDLE. vault_cash = min(vault_cash+load_amt, 2^AMT_W-1), saturating. It is ignored in other states.
- A dispense and a load never coincide, because of the state gating.
- Asynchronous reset mid-transaction: immediate return to reset values. The vault is reinitialised to INIT_CASH.

Decomposition:
- Package atm_pkg holds the state enum (encodings above) and a localparam for the tries_left width helper.
- One sub-module, atm_timer: a reusable load/clear down-counter with a terminal flag. It is instantiated twice, once for the inactivity timeout and once for the lockout duration.

Test Plan:
- Reset, then defect=1 for 2 cycles, then defect=0 -> red_bulb=1 during the defect, green_bulb=1 one cycle after release; vault_cash=100.
- Insert card with card_valid=0, card_undamaged=1 -> resubmit pulses once; card removed -> IDLE, green_bulb=1.
- Valid card, 3 wrong PINs (0000) against correct_pin 0110 -> tries_left goes 2, 1, 0; alarm high for exactly 8 cycles; no success.
- Correct PIN 0110, amount 110 with vault 100 -> not_enough_cash pulses, state stays WAIT_AMT; then amount 10 -> success pulse, dispense_amt=10, vault_cash=90.
- Valid card with no strobe for 32 cycles -> DONE; card removed -> IDLE.
- Vault driven to 0 by a dispense of 100 -> OOS after card removal; load_strobe with load_amt=65535 on vault 0, then a second load of 5 -> vault_cash=65535 (saturated), state IDLE.

Source files
------------

// File: rtl/atm_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the ATM transaction controller:
//   state_e     - controller state encoding (also exported on state_o)
//   STATE_W     - width of the state encoding
//   tries_w()   - width needed to hold a PIN-attempt count 0..max_tries
//   DEF_TRIES_W - tries_left width for the default of three attempts
// -----------------------------------------------------------------------------
package atm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OOS      = 3'd0,
        ST_IDLE     = 3'd1,
        ST_CHECK    = 3'd2,
        ST_WAIT_PIN = 3'd3,
        ST_WAIT_AMT = 3'd4,
        ST_DONE     = 3'd5,
        ST_LOCKOUT  = 3'd6
    } state_e;

    function automatic int tries_w(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

    localparam int DEF_TRIES_W = tries_w(3);

endpackage

// File: rtl/atm_ctrl_param_if.sv
// -----------------------------------------------------------------------------
// atm_ctrl_param_if
// Front-end / dispenser bundle of the ATM controller.
//   master : card reader, keypad, vault loader and status consumers
//            (drives defect, card, PIN, amount and load signals)
//   slave  : the controller (drives bulbs, pulses, dispense amount, vault
//            balance, tries_left and the debug state)
// -----------------------------------------------------------------------------
interface atm_ctrl_param_if
    import atm_pkg::*;
#(
    parameter int AMT_W   = 16,
    parameter int PIN_W   = 4,
    parameter int TRIES_W = DEF_TRIES_W
);
    logic               defect;
    logic               insert_card;
    logic               card_valid;
    logic               card_undamaged;
    logic               pin_strobe;
    logic [PIN_W-1:0]   user_pin;
    logic [PIN_W-1:0]   correct_pin;
    logic               amt_strobe;
    logic [AMT_W-1:0]   amount_asked;
    logic               load_strobe;
    logic [AMT_W-1:0]   load_amt;

    logic               green_bulb;
    logic               red_bulb;
    logic               resubmit;
    logic               alarm;
    logic               not_enough_cash;
    logic               success;
    logic [AMT_W-1:0]   dispense_amt;
    logic [AMT_W-1:0]   vault_cash;
    logic [TRIES_W-1:0] tries_left;
    logic [STATE_W-1:0] state_o;

    modport master (
        output defect, insert_card, card_valid, card_undamaged,
               pin_strobe, user_pin, correct_pin,
               amt_strobe, amount_asked, load_strobe, load_amt,
        input  green_bulb, red_bulb, resubmit, alarm, not_enough_cash,
               success, dispense_amt, vault_cash, tries_left, state_o
    );

    modport slave (
        input  defect, insert_card, card_valid, card_undamaged,
               pin_strobe, user_pin, correct_pin,
               amt_strobe, amount_asked, load_strobe, load_amt,
        output green_bulb, red_bulb, resubmit, alarm, not_enough_cash,
               success, dispense_amt, vault_cash, tries_left, state_o
    );

endinterface

// File: rtl/atm_timer.sv
// -----------------------------------------------------------------------------
// atm_timer
// Load/hold down-counter with a terminal flag.
//   clock, reset : clock and asynchronous active-high reset
//   load_i       : load load_val_i (has priority over counting)
//   load_val_i   : reload value
//   en_i         : count down by one per cycle, stopping at zero
//   zero_o       : counter is at zero (terminal)
// -----------------------------------------------------------------------------
module atm_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);
    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of the order blocks are evaluated.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/atm_ctrl_param.sv
// -----------------------------------------------------------------------------
// atm_ctrl_param
// Registered-output ATM transaction controller with an internal vault,
// PIN retry limit, timed alarm lockout and inactivity timeout.
//   clock, reset : clock and asynchronous active-high reset
//   bus (slave)  : card/keypad/loader inputs; bulbs, pulses, dispense amount,
//                  vault balance, remaining PIN tries and debug state outputs
// -----------------------------------------------------------------------------
module atm_ctrl_param
    import atm_pkg::*;
#(
    parameter int AMT_W     = 16,
    parameter int PIN_W     = 4,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 32,
    parameter int LOCK_CYC  = 8,
    parameter int INIT_CASH = 100
) (
    input  logic           clock,
    input  logic           reset,
    atm_ctrl_param_if.slave bus
);
    localparam int TRIES_W = tries_w(MAX_TRIES);
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);
    localparam int LOCK_W  = $clog2(LOCK_CYC + 1);

    state_e             state_q;
    logic [AMT_W-1:0]   vault_q;
    logic [AMT_W-1:0]   dispense_q;
    logic [TRIES_W-1:0] tries_q;
    logic               resubmit_q;
    logic               nec_q;
    logic               success_q;
    logic               alarm_q;

    logic               any_strobe;
    logic               in_wait;
    logic               idle_zero;
    logic               lock_zero;
    logic               pin_match;
    logic               load_ok;
    logic [AMT_W:0]     load_sum;
    logic [AMT_W-1:0]   load_sat;

    assign any_strobe = bus.pin_strobe | bus.amt_strobe | bus.load_strobe;
    assign in_wait    = (state_q == ST_WAIT_PIN) || (state_q == ST_WAIT_AMT);
    assign pin_match  = (PIN_W'(bus.user_pin) == PIN_W'(bus.correct_pin));

    // Reloads are only taken while no transaction is open, so they can never
    // coincide with a dispense.
    assign load_ok  = bus.load_strobe && ((state_q == ST_OOS) || (state_q == ST_IDLE));
    assign load_sum = {1'b0, vault_q} + {1'b0, bus.load_amt};
    assign load_sat = load_sum[AMT_W] ? '1 : load_sum[AMT_W-1:0];

    // Both timers are held at their reload value while outside the states that
    // use them, so entering such a state starts a fresh count with no extra
    // entry-detect logic. Any strobe restarts the inactivity window.
    atm_timer #(.W(IDLE_W)) u_idle_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (!in_wait || any_strobe),
        .load_val_i (IDLE_W'(TIMEOUT - 1)),
        .en_i       (in_wait),
        .zero_o     (idle_zero)
    );

    atm_timer #(.W(LOCK_W)) u_lock_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (state_q != ST_LOCKOUT),
        .load_val_i (LOCK_W'(LOCK_CYC - 1)),
        .en_i       (state_q == ST_LOCKOUT),
        .zero_o     (lock_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= (INIT_CASH == 0) ? ST_OOS : ST_IDLE;
            vault_q    <= AMT_W'(INIT_CASH);
            dispense_q <= '0;
            tries_q    <= TRIES_W'(MAX_TRIES);
            resubmit_q <= 1'b0;
            nec_q      <= 1'b0;
            success_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            resubmit_q <= 1'b0;
            nec_q      <= 1'b0;
            success_q  <= 1'b0;
            alarm_q    <= 1'b0;

            if (load_ok) begin
                vault_q <= load_sat;
            end

            // Priority in the transaction states: defect, then card removal,
            // then strobes, then inactivity timeout.
            unique case (state_q)
                ST_OOS: begin
                    if (!bus.defect && (vault_q != '0)) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.defect)           state_q <= ST_OOS;
                    else if (bus.insert_card) state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (bus.defect) begin
                        state_q <= ST_OOS;
                    end else if (!bus.insert_card) begin
                        state_q <= ST_IDLE;
                    end else if (bus.card_valid && bus.card_undamaged) begin
                        state_q <= ST_WAIT_PIN;
                        tries_q <= TRIES_W'(MAX_TRIES);
                    end else begin
                        resubmit_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_WAIT_PIN: begin
                    if (bus.defect) begin
                        state_q <= ST_OOS;
                    end else if (!bus.insert_card) begin
                        state_q <= ST_IDLE;
                    end else if (bus.pin_strobe) begin
                        if (pin_match) begin
                            state_q <= ST_WAIT_AMT;
                        end else begin
                            tries_q <= tries_q - TRIES_W'(1);
                            if (tries_q == TRIES_W'(1)) begin
                                state_q <= ST_LOCKOUT;
                                alarm_q <= 1'b1;
                            end
                        end
                    end else if (idle_zero && !any_strobe) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_WAIT_AMT: begin
                    if (bus.defect) begin
                        state_q <= ST_OOS;
                    end else if (!bus.insert_card) begin
                        state_q <= ST_IDLE;
                    end else if (bus.amt_strobe) begin
                        if (bus.amount_asked == '0) begin
                            state_q <= ST_DONE;
                        end else if (bus.amount_asked > vault_q) begin
                            nec_q <= 1'b1;
                        end else begin
                            success_q  <= 1'b1;
                            dispense_q <= bus.amount_asked;
                            vault_q    <= vault_q - bus.amount_asked;
                            state_q    <= ST_DONE;
                        end
                    end else if (idle_zero && !any_strobe) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.defect) begin
                        state_q <= ST_OOS;
                    end else if (!bus.insert_card) begin
                        state_q <= (vault_q == '0) ? ST_OOS : ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    // Lockout runs to completion even under a defect.
                    if (lock_zero) state_q <= ST_DONE;
                    else           alarm_q <= 1'b1;
                end
                default: state_q <= ST_OOS;
            endcase
        end
    end

    assign bus.green_bulb      = (state_q == ST_IDLE);
    assign bus.red_bulb        = (state_q == ST_OOS);
    assign bus.resubmit        = resubmit_q;
    assign bus.alarm           = alarm_q;
    assign bus.not_enough_cash = nec_q;
    assign bus.success         = success_q;
    assign bus.dispense_amt    = dispense_q;
    assign bus.vault_cash      = vault_q;
    assign bus.tries_left      = tries_q;
    assign bus.state_o         = state_q;

endmodule

// File: tb/tb_atm_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_atm_ctrl_param
// Directed scenarios plus randomized traffic for atm_ctrl_param, checked
// against a transaction-level reference model kept in this bench.
// -----------------------------------------------------------------------------
module tb_atm_ctrl_param;

    localparam int AMT_W     = 16;
    localparam int PIN_W     = 4;
    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT   = 32;
    localparam int LOCK_CYC  = 8;
    localparam int INIT_CASH = 100;
    localparam int TRIES_W   = $clog2(MAX_TRIES + 1);
    localparam int MAXV      = (1 << AMT_W) - 1;
    localparam int VW        = 9 + TRIES_W + AMT_W;

    localparam int S_OOS = 0, S_IDLE = 1, S_CHECK = 2, S_WAIT_PIN = 3;
    localparam int S_WAIT_AMT = 4, S_DONE = 5, S_LOCKOUT = 6;

    logic clock;
    logic reset;

    atm_ctrl_param_if #(.AMT_W(AMT_W), .PIN_W(PIN_W), .TRIES_W(TRIES_W)) bus ();

    atm_ctrl_param #(
        .AMT_W(AMT_W), .PIN_W(PIN_W), .MAX_TRIES(MAX_TRIES),
        .TIMEOUT(TIMEOUT), .LOCK_CYC(LOCK_CYC), .INIT_CASH(INIT_CASH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit succ_seen;

    // Reference model: session phase, vault, tries, cycles idle in the
    // current waiting state and cycles spent in lockout.
    int m_state, m_vault, m_tries, m_idle, m_lock, m_disp;
    bit m_resub, m_nec, m_succ, m_alarm;

    task automatic model_reset();
        m_state = (INIT_CASH == 0) ? S_OOS : S_IDLE;
        m_vault = INIT_CASH;
        m_tries = MAX_TRIES;
        m_idle  = 0;
        m_lock  = 0;
        m_disp  = 0;
        m_resub = 0; m_nec = 0; m_succ = 0; m_alarm = 0;
    endtask

    task automatic model_step();
        int ns, nv;
        bit strobe, abort;
        ns = m_state;
        nv = m_vault;
        m_resub = 0; m_nec = 0; m_succ = 0;
        strobe = bus.pin_strobe || bus.amt_strobe || bus.load_strobe;
        abort  = !bus.insert_card;
        if ((m_state == S_OOS || m_state == S_IDLE) && bus.load_strobe) begin
            nv = m_vault + int'(bus.load_amt);
            if (nv > MAXV) nv = MAXV;
        end
        if (m_state == S_LOCKOUT) begin
            if (m_lock == LOCK_CYC - 1) ns = S_DONE;
        end else if (bus.defect) begin
            ns = S_OOS;
        end else begin
            case (m_state)
                S_OOS:  if (m_vault != 0) ns = S_IDLE;
                S_IDLE: if (bus.insert_card) ns = S_CHECK;
                S_CHECK: begin
                    if (abort) ns = S_IDLE;
                    else if (bus.card_valid && bus.card_undamaged) begin
                        ns = S_WAIT_PIN; m_tries = MAX_TRIES;
                    end else begin
                        ns = S_DONE; m_resub = 1;
                    end
                end
                S_WAIT_PIN: begin
                    if (abort) ns = S_IDLE;
                    else if (bus.pin_strobe) begin
                        if (bus.user_pin == bus.correct_pin) ns = S_WAIT_AMT;
                        else begin
                            m_tries = m_tries - 1;
                            if (m_tries == 0) ns = S_LOCKOUT;
                        end
                    end else if (!strobe && m_idle == TIMEOUT - 1) ns = S_DONE;
                end
                S_WAIT_AMT: begin
                    if (abort) ns = S_IDLE;
                    else if (bus.amt_strobe) begin
                        if (bus.amount_asked == 0) ns = S_DONE;
                        else if (int'(bus.amount_asked) > m_vault) m_nec = 1;
                        else begin
                            m_succ = 1;
                            m_disp = int'(bus.amount_asked);
                            nv = m_vault - m_disp;
                            ns = S_DONE;
                        end
                    end else if (!strobe && m_idle == TIMEOUT - 1) ns = S_DONE;
                end
                S_DONE: if (abort) ns = (m_vault == 0) ? S_OOS : S_IDLE;
                default: ns = S_OOS;
            endcase
        end
        m_idle  = (ns != m_state || strobe) ? 0 : m_idle + 1;
        m_lock  = (ns != m_state) ? 0 : m_lock + 1;
        m_alarm = (ns == S_LOCKOUT);
        m_state = ns;
        m_vault = nv;
    endtask

    // One clock: model consumes the inputs now on the bus, DUT samples them on
    // the edge, outputs are observed 1 ns later. Strobes last one cycle.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        bus.pin_strobe  = 0;
        bus.amt_strobe  = 0;
        bus.load_strobe = 0;
        if (bus.success) succ_seen = 1;
    endtask

    task automatic clear_inputs();
        bus.defect = 0; bus.insert_card = 0; bus.card_valid = 0;
        bus.card_undamaged = 0; bus.pin_strobe = 0; bus.user_pin = '0;
        bus.correct_pin = 4'b0110; bus.amt_strobe = 0; bus.amount_asked = '0;
        bus.load_strobe = 0; bus.load_amt = '0;
    endtask

    // Card in and accepted: IDLE -> CHECK -> WAIT_PIN.
    task automatic open_session();
        bus.insert_card = 1; bus.card_valid = 1; bus.card_undamaged = 1;
        tick();
        tick();
    endtask

    task automatic enter_pin_ok();
        bus.user_pin = bus.correct_pin; bus.pin_strobe = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #12;
        model_reset();
        n_checks++;
        if (bus.vault_cash !== 16'd100) begin
            n_errors++; $display("FAIL reset_vault: got %0d expected 100", bus.vault_cash);
        end
        n_checks++;
        if ({bus.state_o, bus.tries_left, bus.green_bulb, bus.red_bulb} !== {3'd1, 2'd3, 1'b1, 1'b0}) begin
            n_errors++; $display("FAIL reset_state: got st=%0d tries=%0d g=%0b r=%0b expected st=1 tries=3 g=1 r=0",
                                 bus.state_o, bus.tries_left, bus.green_bulb, bus.red_bulb);
        end
        n_checks++;
        if ({bus.resubmit, bus.alarm, bus.not_enough_cash, bus.success, bus.dispense_amt} !== '0) begin
            n_errors++; $display("FAIL reset_pulses: got res=%0b al=%0b nec=%0b suc=%0b disp=%0d expected all 0",
                                 bus.resubmit, bus.alarm, bus.not_enough_cash, bus.success, bus.dispense_amt);
        end
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    task automatic test_defect();
        bus.defect = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (bus.red_bulb !== 1'b1 || bus.green_bulb !== 1'b0) begin
                n_errors++; $display("FAIL defect_red[%0d]: got r=%0b g=%0b expected r=1 g=0", i, bus.red_bulb, bus.green_bulb);
            end
        end
        bus.defect = 0;
        tick();
        n_checks++;
        if (bus.green_bulb !== 1'b1 || bus.vault_cash !== 16'd100) begin
            n_errors++; $display("FAIL defect_release: got g=%0b vault=%0d expected g=1 vault=100", bus.green_bulb, bus.vault_cash);
        end
    endtask

    task automatic test_bad_card();
        int pulses = 0;
        bus.insert_card = 1; bus.card_valid = 0; bus.card_undamaged = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.resubmit) pulses++;
        end
        n_checks++;
        if (pulses != 1 || bus.state_o !== 3'd5) begin
            n_errors++; $display("FAIL bad_card_resubmit: got pulses=%0d st=%0d expected pulses=1 st=5", pulses, bus.state_o);
        end
        bus.insert_card = 0;
        tick();
        n_checks++;
        if (bus.green_bulb !== 1'b1 || bus.state_o !== 3'd1) begin
            n_errors++; $display("FAIL bad_card_idle: got g=%0b st=%0d expected g=1 st=1", bus.green_bulb, bus.state_o);
        end
    endtask

    task automatic test_lockout();
        int alarm_cycles;
        succ_seen = 0;
        bus.correct_pin = 4'b0110;
        open_session();
        for (int i = 0; i < MAX_TRIES; i++) begin
            bus.user_pin = 4'b0000; bus.pin_strobe = 1;
            tick();
            n_checks++;
            if (bus.tries_left !== TRIES_W'(MAX_TRIES - 1 - i)) begin
                n_errors++; $display("FAIL lockout_tries[%0d]: got %0d expected %0d", i, bus.tries_left, MAX_TRIES - 1 - i);
            end
            if (i < MAX_TRIES - 1) tick();
        end
        alarm_cycles = bus.alarm ? 1 : 0;
        for (int i = 0; i < 40 && bus.alarm; i++) begin
            bus.pin_strobe = 1; bus.user_pin = 4'b0110;   // ignored in lockout
            tick();
            if (bus.alarm) alarm_cycles++;
        end
        n_checks++;
        if (alarm_cycles != LOCK_CYC || bus.state_o !== 3'd5 || succ_seen) begin
            n_errors++; $display("FAIL lockout_alarm: got cycles=%0d st=%0d success=%0b expected cycles=%0d st=5 success=0",
                                 alarm_cycles, bus.state_o, succ_seen, LOCK_CYC);
        end
        bus.insert_card = 0;
        tick();
    endtask

    task automatic test_dispense();
        open_session();
        enter_pin_ok();
        bus.amount_asked = 16'd110; bus.amt_strobe = 1;
        tick();
        n_checks++;
        if (bus.not_enough_cash !== 1'b1 || bus.state_o !== 3'd4 || bus.vault_cash !== 16'd100) begin
            n_errors++; $display("FAIL dispense_nec: got nec=%0b st=%0d vault=%0d expected nec=1 st=4 vault=100",
                                 bus.not_enough_cash, bus.state_o, bus.vault_cash);
        end
        tick();
        n_checks++;
        if (bus.not_enough_cash !== 1'b0) begin
            n_errors++; $display("FAIL dispense_nec_pulse: got nec=%0b expected 0", bus.not_enough_cash);
        end
        bus.amount_asked = 16'd10; bus.amt_strobe = 1;
        tick();
        n_checks++;
        if (bus.success !== 1'b1 || bus.dispense_amt !== 16'd10 || bus.vault_cash !== 16'd90 || bus.state_o !== 3'd5) begin
            n_errors++; $display("FAIL dispense_ok: got suc=%0b amt=%0d vault=%0d st=%0d expected suc=1 amt=10 vault=90 st=5",
                                 bus.success, bus.dispense_amt, bus.vault_cash, bus.state_o);
        end
        bus.insert_card = 0;
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        open_session();
        do begin
            tick();
            n++;
        end while (bus.state_o !== 3'd5 && n < 100);
        n_checks++;
        if (n != TIMEOUT) begin
            n_errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT);
        end
        bus.insert_card = 0;
        tick();
        n_checks++;
        if (bus.state_o !== 3'd1) begin
            n_errors++; $display("FAIL timeout_idle: got st=%0d expected 1", bus.state_o);
        end
    endtask

    // Card pulled in the same cycle as an amount strobe: abort wins.
    task automatic test_abort_priority();
        succ_seen = 0;
        open_session();
        enter_pin_ok();
        bus.insert_card = 0; bus.amount_asked = 16'd5; bus.amt_strobe = 1;
        tick();
        n_checks++;
        if (bus.state_o !== 3'd1 || succ_seen || bus.vault_cash !== 16'd90) begin
            n_errors++; $display("FAIL abort_priority: got st=%0d success=%0b vault=%0d expected st=1 success=0 vault=90",
                                 bus.state_o, succ_seen, bus.vault_cash);
        end
    endtask

    // Defect in the same cycle as an amount strobe: strobe dropped.
    task automatic test_defect_drop();
        succ_seen = 0;
        open_session();
        enter_pin_ok();
        bus.defect = 1; bus.amount_asked = 16'd5; bus.amt_strobe = 1;
        tick();
        n_checks++;
        if (bus.state_o !== 3'd0 || succ_seen || bus.vault_cash !== 16'd90) begin
            n_errors++; $display("FAIL defect_drop: got st=%0d success=%0b vault=%0d expected st=0 success=0 vault=90",
                                 bus.state_o, succ_seen, bus.vault_cash);
        end
        bus.defect = 0; bus.insert_card = 0;
        tick();
    endtask

    task automatic test_async_reset();
        open_session();
        enter_pin_ok();
        bus.amount_asked = 16'd20; bus.amt_strobe = 1;
        tick();
        #2;
        reset = 1;
        #1;
        model_reset();
        n_checks++;
        if (bus.vault_cash !== 16'd100 || bus.state_o !== 3'd1 || bus.tries_left !== 2'd3 || bus.dispense_amt !== '0) begin
            n_errors++; $display("FAIL async_reset: got vault=%0d st=%0d tries=%0d disp=%0d expected 100/1/3/0",
                                 bus.vault_cash, bus.state_o, bus.tries_left, bus.dispense_amt);
        end
        clear_inputs();
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    task automatic test_empty_and_load();
        open_session();
        enter_pin_ok();
        bus.amount_asked = 16'd100; bus.amt_strobe = 1;
        tick();
        bus.insert_card = 0;
        tick();
        n_checks++;
        if (bus.vault_cash !== '0 || bus.state_o !== 3'd0 || bus.red_bulb !== 1'b1) begin
            n_errors++; $display("FAIL empty_oos: got vault=%0d st=%0d r=%0b expected 0/0/1", bus.vault_cash, bus.state_o, bus.red_bulb);
        end
        bus.load_amt = 16'hFFFF; bus.load_strobe = 1;
        tick();
        tick();
        bus.load_amt = 16'd5; bus.load_strobe = 1;
        tick();
        n_checks++;
        if (bus.vault_cash !== 16'hFFFF || bus.state_o !== 3'd1) begin
            n_errors++; $display("FAIL load_saturate: got vault=%0d st=%0d expected 65535 st=1", bus.vault_cash, bus.state_o);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] got, exp;
        int strobe_div;
        for (int blk = 0; blk < 8; blk++) begin
            strobe_div = (blk % 2 == 0) ? 3 : 40;   // dense vs sparse strobes
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 14) == 0) bus.insert_card = ~bus.insert_card;
                bus.defect         = ($urandom_range(0, 79) == 0);
                bus.card_valid     = ($urandom_range(0, 5) != 0);
                bus.card_undamaged = ($urandom_range(0, 5) != 0);
                bus.correct_pin    = PIN_W'($urandom_range(0, 15));
                bus.user_pin       = $urandom_range(0, 1) ? bus.correct_pin : PIN_W'($urandom_range(0, 15));
                bus.pin_strobe     = ($urandom_range(0, strobe_div) == 0);
                bus.amt_strobe     = ($urandom_range(0, strobe_div) == 0);
                bus.amount_asked   = ($urandom_range(0, 5) == 0) ? '0 : AMT_W'($urandom_range(1, 70));
                bus.load_strobe    = ($urandom_range(0, 4 * strobe_div) == 0);
                bus.load_amt       = ($urandom_range(0, 9) == 0) ? AMT_W'($urandom_range(60000, 65535))
                                                                 : AMT_W'($urandom_range(0, 150));
                tick();
                exp = {m_state == S_IDLE, m_state == S_OOS, m_resub, m_alarm, m_nec, m_succ,
                       3'(m_state), TRIES_W'(m_tries), AMT_W'(m_vault)};
                got = {bus.green_bulb, bus.red_bulb, bus.resubmit, bus.alarm, bus.not_enough_cash,
                       bus.success, bus.state_o, bus.tries_left, bus.vault_cash};
                n_checks++;
                if (got !== exp) begin
                    n_errors++; $display("FAIL random_outputs[%0d.%0d]: got %h expected %h", blk, c, got, exp);
                end
                if (m_succ) begin
                    n_checks++;
                    if (bus.dispense_amt !== AMT_W'(m_disp)) begin
                        n_errors++; $display("FAIL random_dispense[%0d.%0d]: got %0d expected %0d", blk, c, bus.dispense_amt, m_disp);
                    end
                end
            end
        end
    endtask

    initial begin
        clock = 0;
        reset = 1;
        test_reset();
        test_defect();
        test_bad_card();
        test_lockout();
        test_dispense();
        test_timeout();
        test_abort_priority();
        test_defect_drop();
        test_async_reset();
        test_empty_and_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
